// File: rtl/paint_pkg.sv
// Shared definitions for the paint pipeline.
//   X_W/Y_W/COLOUR_W   default coordinate and colour widths (160x120, RGB)
//   SCREEN_W/SCREEN_H  visible area; pixels outside it are clipped
//   state_t            draw-engine FSM states
//   BLACK/WHITE        colour constants
package paint_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SCAN,
        S_DONE
    } state_t;

endpackage

// File: rtl/rect_draw_engine_scan_counter.sv
// Row-major scan counter for the rectangle engine.
//   Clock, Reset     clock / synchronous active-high reset
//   load             load cx=xmin, cy=ymin
//   step             advance one pixel (wraps cx to xmin at xmax, bumps cy)
//   xmin..ymax       rectangle bounds (stable for the whole draw)
//   cx, cy           current pixel
//   last             current pixel is (xmax, ymax)
//   on_edge          current pixel lies on the rectangle outline
module rect_scan_counter
    import paint_pkg::*;
#(
    parameter int X_W = paint_pkg::X_W,
    parameter int Y_W = paint_pkg::Y_W
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] xmin,
    input  logic [X_W-1:0] xmax,
    input  logic [Y_W-1:0] ymin,
    input  logic [Y_W-1:0] ymax,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last,
    output logic           on_edge
);

    // Equality against the max bound means the counters never have to
    // step past the top coordinate, so xmax=255 cannot wrap the scan.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cx <= '0;
            cy <= '0;
        end else if (load) begin
            cx <= xmin;
            cy <= ymin;
        end else if (step) begin
            if (cx == xmax) begin
                cx <= xmin;
                cy <= cy + Y_W'(1);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

    assign last    = (cx == xmax) && (cy == ymax);
    assign on_edge = (cx == xmin) || (cx == xmax) || (cy == ymin) || (cy == ymax);

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle pixel generator: latches two corners, colour and fill mode on
// start, then emits one registered pixel write per cycle in row-major order.
//   Clock, Reset        clock / synchronous active-high reset
//   start               draw request, sampled only while idle
//   x0,y0 / x1,y1       corners, any order
//   colour, fill        draw colour; 1 = filled, 0 = outline
//   busy, done          handshake to the paint controller
//   plot, x_out, y_out, colour_out   pixel write to the VGA adapter
module rect_draw_engine
    import paint_pkg::*;
#(
    parameter int X_W      = paint_pkg::X_W,
    parameter int Y_W      = paint_pkg::Y_W,
    parameter int COLOUR_W = paint_pkg::COLOUR_W,
    parameter int SCREEN_W = paint_pkg::SCREEN_W,
    parameter int SCREEN_H = paint_pkg::SCREEN_H
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                fill,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out
);

    state_t state, state_nx;

    logic [X_W-1:0]      ax, bx;
    logic [Y_W-1:0]      ay, by;
    logic [COLOUR_W-1:0] col_q;
    logic                fill_q;

    logic [X_W-1:0] xmin, xmax, cx;
    logic [Y_W-1:0] ymin, ymax, cy;
    logic           last, on_edge, scan_plot;

    // Request is captured once; later input changes cannot disturb a draw.
    always_ff @(posedge Clock) begin
        if (state == S_IDLE && start) begin
            ax     <= x0;
            ay     <= y0;
            bx     <= x1;
            by     <= y1;
            col_q  <= colour;
            fill_q <= fill;
        end
    end

    // Bounds derive from the latched corners, so they hold steady for the
    // whole draw without a separate register stage.
    assign xmin = (ax < bx) ? ax : bx;
    assign xmax = (ax < bx) ? bx : ax;
    assign ymin = (ay < by) ? ay : by;
    assign ymax = (ay < by) ? by : ay;

    rect_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (state == S_SETUP),
        .step    (state == S_SCAN),
        .xmin    (xmin),
        .xmax    (xmax),
        .ymin    (ymin),
        .ymax    (ymax),
        .cx      (cx),
        .cy      (cy),
        .last    (last),
        .on_edge (on_edge)
    );

    assign scan_plot = (state == S_SCAN) && (fill_q || on_edge)
                     && (32'(cx) < SCREEN_W) && (32'(cy) < SCREEN_H);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_SETUP;
            S_SETUP: state_nx = S_SCAN;
            S_SCAN:  if (last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // with the state register: busy over SETUP/SCAN, done during DONE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= COLOUR_W'(BLACK);
        end else begin
            state <= state_nx;
            busy  <= (state_nx == S_SETUP) || (state_nx == S_SCAN);
            done  <= (state_nx == S_DONE);
            plot  <= scan_plot;
            if (scan_plot) begin
                x_out      <= cx;
                y_out      <= cy;
                colour_out <= col_q;
            end
        end
    end

endmodule

// File: tb/tb_rect_draw_engine.sv
module tb_rect_draw_engine;
    import paint_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset, start, fill;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour;
    logic       busy, done, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    always #5 Clock = ~Clock;

    rect_draw_engine dut (
        .Clock(Clock), .Reset(Reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .colour(colour), .fill(fill),
        .busy(busy), .done(done), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: per-edge expected outputs, built from the rectangle
    // rules when a request is accepted.
    typedef struct { bit plot; int x; int y; int c; bit busy; bit done; } exp_t;
    exp_t exp_q[$];
    exp_t cur = '{default: 0};
    int   cyc = 0, free_at = 0;
    bit   armed = 0;

    function automatic void queue_rect(int ax, int ay, int bx, int by, int c, bit f);
        int   xl = (ax < bx) ? ax : bx;
        int   xh = (ax < bx) ? bx : ax;
        int   yl = (ay < by) ? ay : by;
        int   yh = (ay < by) ? by : ay;
        int   s  = (xh - xl + 1) * (yh - yl + 1);
        int   k  = 0;
        exp_t e  = '{default: 0};
        e.busy = 1;
        exp_q.push_back(e);   // accept edge
        exp_q.push_back(e);   // setup edge
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                k++;
                e.plot = (f || x == xl || x == xh || y == yl || y == yh) && x < 160 && y < 120;
                e.x = x; e.y = y; e.c = c;
                e.busy = (k < s);
                e.done = (k == s);
                exp_q.push_back(e);
            end
        free_at = cyc + s + 3;
    endfunction

    always @(posedge Clock) begin
        cyc++;
        if (Reset) begin
            exp_q.delete();
            cur = '{default: 0};
            free_at = cyc + 1;
            armed = 1;
        end else begin
            if (armed && start && cyc >= free_at)
                queue_rect(int'(x0), int'(y0), int'(x1), int'(y1), int'(colour), fill);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{default: 0};
        end
    end

    // Compare against the model and log observed activity.
    typedef struct { int x; int y; int c; int cyc; } pix_t;
    pix_t log_q[$];
    int   done_cnt = 0, busy_cnt = 0;

    always @(negedge Clock) begin
        if (armed) begin
            chk("plot", int'(plot), int'(cur.plot));
            chk("busy", int'(busy), int'(cur.busy));
            chk("done", int'(done), int'(cur.done));
            if (cur.plot) begin
                chk("x_out", int'(x_out), cur.x);
                chk("y_out", int'(y_out), cur.y);
                chk("colour_out", int'(colour_out), cur.c);
            end
            if (plot) log_q.push_back('{int'(x_out), int'(y_out), int'(colour_out), cyc});
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    end

    function automatic int px(int i);
        if (i >= log_q.size()) return -1;
        return log_q[i].x * 256 + log_q[i].y;
    endfunction

    task automatic draw(int ax, int ay, int bx, int by, int c, bit f, output int acc);
        @(posedge Clock); #1;
        x0 = 8'(ax); y0 = 7'(ay); x1 = 8'(bx); y1 = 7'(by);
        colour = 3'(c); fill = f; start = 1'b1;
        @(posedge Clock); #1;
        acc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge Clock);
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        repeat (2) @(posedge Clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, d0;
        Reset = 1'b1; start = 1'b0; fill = 1'b0; colour = '0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_colour_out", int'(colour_out), int'(BLACK));
        chk("rst_busy", int'(busy), 0);
        Reset = 1'b0;

        // 1: filled 3x3
        log_q.delete(); d0 = done_cnt;
        draw(2, 3, 4, 5, 4, 1'b1, acc);
        wait_done(d0);
        chk("t1_plots", log_q.size(), 9);
        chk("t1_latency", (log_q.size() > 0) ? log_q[0].cyc - acc : -1, 2);
        chk("t1_p0", px(0), 2 * 256 + 3);
        chk("t1_p3", px(3), 2 * 256 + 4);
        chk("t1_p8", px(8), 4 * 256 + 5);
        chk("t1_colour", (log_q.size() > 0) ? log_q[0].c : -1, 4);
        chk("t1_done", done_cnt - d0, 1);

        // 2: outline 4x3
        log_q.delete(); d0 = done_cnt;
        draw(10, 10, 13, 12, 3, 1'b0, acc);
        wait_done(d0);
        chk("t2_plots", log_q.size(), 10);
        chk("t2_p0", px(0), 10 * 256 + 10);
        chk("t2_p4", px(4), 10 * 256 + 11);
        chk("t2_p5", px(5), 13 * 256 + 11);

        // 3: swapped corners, then a single pixel
        log_q.delete(); d0 = done_cnt;
        draw(7, 9, 5, 8, 2, 1'b0, acc);
        wait_done(d0);
        chk("t3_plots", log_q.size(), 6);
        chk("t3_p0", px(0), 5 * 256 + 8);
        chk("t3_p3", px(3), 5 * 256 + 9);
        chk("t3_p5", px(5), 7 * 256 + 9);
        log_q.delete(); d0 = done_cnt;
        draw(0, 0, 0, 0, 7, 1'b1, acc);
        wait_done(d0);
        chk("t3_single_plots", log_q.size(), 1);
        chk("t3_single_p0", px(0), 0);
        chk("t3_single_done", done_cnt - d0, 1);

        // 4: clipping at the bottom-right screen corner
        log_q.delete(); d0 = done_cnt; busy_cnt = 0;
        draw(158, 118, 161, 119, 1, 1'b1, acc);
        wait_done(d0);
        chk("t4_plots", log_q.size(), 4);
        chk("t4_p1", px(1), 159 * 256 + 118);
        chk("t4_p3", px(3), 159 * 256 + 119);
        chk("t4_busy_cycles", busy_cnt, 9);

        // 5: start pulses and input changes during a draw
        log_q.delete(); d0 = done_cnt;
        draw(20, 20, 23, 22, int'(WHITE), 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            start = 1'b1; x0 = 8'(100 + i); y0 = 7'(50); x1 = 8'(0); y1 = 7'(0); fill = 1'b0;
            @(posedge Clock); #1;
            start = 1'b0;
        end
        wait_done(d0);
        repeat (20) @(posedge Clock);
        chk("t5_plots", log_q.size(), 12);
        chk("t5_last", px(11), 23 * 256 + 22);
        chk("t5_done", done_cnt - d0, 1);

        // 6: reset on the 3rd plot of a 4x4 fill, then redraw
        log_q.delete(); d0 = done_cnt;
        draw(0, 0, 3, 3, 5, 1'b1, acc);
        begin
            int n = 0;
            while (log_q.size() < 3 && n < 100) begin
                @(negedge Clock); #1;
                n++;
            end
            if (log_q.size() < 3) chk("t6_third_plot_timeout", 0, 1);
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock); #1;
        chk("t6_plot_after_rst", int'(plot), 0);
        chk("t6_busy_after_rst", int'(busy), 0);
        repeat (20) @(posedge Clock);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_plots", log_q.size(), 3);
        log_q.delete(); d0 = done_cnt;
        draw(1, 1, 2, 2, 2, 1'b0, acc);
        wait_done(d0);
        chk("t6_redraw_plots", log_q.size(), 4);
        chk("t6_redraw_p3", px(3), 2 * 256 + 2);
        chk("t6_redraw_done", done_cnt - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
